hilo_muldiv: RTL and testbench



---
 rtl/hilo_muldiv_pkg.sv | 36 +++
 rtl/muldiv_core.sv | 90 +++++++++
 rtl/hilo_muldiv.sv | 143 ++++++++++++++
 tb/tb_hilo_muldiv.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/hilo_muldiv_pkg.sv
// hilo_muldiv_pkg: shared definitions for the HI/LO multiply/divide unit.
//   - EXE_*_OP : decoded alucontrol codes that this unit consumes
//   - hm_state_e : control state encoding (HM_IDLE/HM_BUSY/HM_DONE)
//   - helper predicates that classify an alucontrol code
package hilo_muldiv_pkg;

  localparam logic [7:0] EXE_MFHI_OP  = 8'b0001_0000;
  localparam logic [7:0] EXE_MTHI_OP  = 8'b0001_0001;
  localparam logic [7:0] EXE_MFLO_OP  = 8'b0001_0010;
  localparam logic [7:0] EXE_MTLO_OP  = 8'b0001_0011;
  localparam logic [7:0] EXE_MULT_OP  = 8'b0001_1000;
  localparam logic [7:0] EXE_MULTU_OP = 8'b0001_1001;
  localparam logic [7:0] EXE_DIV_OP   = 8'b0001_1010;
  localparam logic [7:0] EXE_DIVU_OP  = 8'b0001_1011;

  typedef enum logic [1:0] {
    HM_IDLE = 2'd0,
    HM_BUSY = 2'd1,
    HM_DONE = 2'd2
  } hm_state_e;

  // True for the four ops that run on the iterative engine.
  function automatic logic is_muldiv_op(input logic [7:0] op);
    return (op == EXE_MULT_OP) || (op == EXE_MULTU_OP) ||
           (op == EXE_DIV_OP)  || (op == EXE_DIVU_OP);
  endfunction

  function automatic logic is_div_op(input logic [7:0] op);
    return (op == EXE_DIV_OP) || (op == EXE_DIVU_OP);
  endfunction

  function automatic logic is_signed_op(input logic [7:0] op);
    return (op == EXE_MULT_OP) || (op == EXE_DIV_OP);
  endfunction

endpackage

// File: rtl/muldiv_core.sv
// muldiv_core: unsigned iterative engine, one bit per cycle.
//   Multiply: shift-add, result = {upper, lower} product.
//   Divide  : restoring subtract, result = {remainder, quotient}.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   start           load operands and begin ITER iterations
//   abort           drop the in-flight operation
//   is_div          1 = divide, 0 = multiply (sampled with start)
//   op_a, op_b      magnitudes: multiplicand/multiplier or dividend/divisor
//   done_c          high during the final iteration cycle
//   result_c        value the accumulator takes at the end of this cycle
module muldiv_core #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned ITER  = WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  input  logic                 is_div,
  input  logic [WIDTH-1:0]     op_a,
  input  logic [WIDTH-1:0]     op_b,
  output logic                 done_c,
  output logic [2*WIDTH-1:0]   result_c
);

  localparam int unsigned CW = (ITER > 1) ? $clog2(ITER) : 1;

  logic [WIDTH-1:0] hi_q, lo_q, opnd_q;
  logic [WIDTH-1:0] hi_n, lo_n;
  logic [WIDTH:0]   sum, addend, rem_sh, diff;
  logic [CW-1:0]    cnt_q;
  logic             busy_q, is_div_q;

  // One iteration of whichever algorithm is loaded.
  always_comb begin
    hi_n   = hi_q;
    lo_n   = lo_q;
    addend = '0;
    sum    = '0;
    rem_sh = '0;
    diff   = '0;
    if (is_div_q) begin
      // Shift the next dividend bit into the partial remainder, try a subtract.
      rem_sh = {hi_q, lo_q[WIDTH-1]};
      diff   = rem_sh - {1'b0, opnd_q};
      hi_n   = diff[WIDTH] ? rem_sh[WIDTH-1:0] : diff[WIDTH-1:0];
      lo_n   = {lo_q[WIDTH-2:0], ~diff[WIDTH]};
    end else begin
      // Add multiplicand when the current multiplier bit is set, then shift right.
      addend = lo_q[0] ? {1'b0, opnd_q} : '0;
      sum    = {1'b0, hi_q} + addend;
      hi_n   = sum[WIDTH:1];
      lo_n   = {sum[0], lo_q[WIDTH-1:1]};
    end
  end

  assign done_c   = busy_q && (cnt_q == '0);
  assign result_c = {hi_n, lo_n};

  always_ff @(posedge clk) begin
    if (rst) begin
      hi_q     <= '0;
      lo_q     <= '0;
      opnd_q   <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      is_div_q <= 1'b0;
    end else if (abort) begin
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else if (start) begin
      hi_q     <= '0;
      lo_q     <= is_div ? op_a : op_b;
      opnd_q   <= is_div ? op_b : op_a;
      is_div_q <= is_div;
      cnt_q    <= CW'(ITER - 1);
      busy_q   <= 1'b1;
    end else if (busy_q) begin
      hi_q <= hi_n;
      lo_q <= lo_n;
      if (cnt_q == '0) begin
        busy_q <= 1'b0;
      end else begin
        cnt_q <= cnt_q - CW'(1);
      end
    end
  end

endmodule

// File: rtl/hilo_muldiv.sv
// hilo_muldiv: execute-stage HI/LO unit (MULT/MULTU/DIV/DIVU/MTHI/MTLO/MFHI/MFLO).
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   start_i        E-stage instruction valid
//   alucontrol_i   decoded op code
//   a_i, b_i       rs / rt operands
//   flush_i        cancel any in-flight op
//   stall_o        pipeline hold request (combinational)
//   hi_o, lo_o     architectural HI/LO registers
//   rdata_o        MFHI/MFLO read data, 0 for other ops (combinational)
module hilo_muldiv
  import hilo_muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [7:0]       alucontrol_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             flush_i,
  output logic             stall_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic [WIDTH-1:0] rdata_o
);

  localparam int unsigned ITER = WIDTH;

  hm_state_e state;

  logic             op_md, op_div, op_signed, core_start, core_done;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [2*WIDTH-1:0] core_result;

  // Latched operation context used when the engine finishes.
  logic [WIDTH-1:0] a_q;
  logic             b_zero_q, div_q, signed_q, neg_q, a_neg_q;

  logic [WIDTH-1:0]   fix_hi, fix_lo;
  logic [2*WIDTH-1:0] prod;

  assign op_md     = is_muldiv_op(alucontrol_i);
  assign op_div    = is_div_op(alucontrol_i);
  assign op_signed = is_signed_op(alucontrol_i);

  assign a_mag = (op_signed && a_i[WIDTH-1]) ? -a_i : a_i;
  assign b_mag = (op_signed && b_i[WIDTH-1]) ? -b_i : b_i;

  assign core_start = !rst && !flush_i && (state == HM_IDLE) && start_i && op_md;

  // Stall covers the accept cycle and every engine cycle; flush/reset drop it at once.
  assign stall_o = !rst && !flush_i &&
                   ((state == HM_BUSY) || ((state == HM_IDLE) && start_i && op_md));

  always_comb begin
    case (alucontrol_i)
      EXE_MFHI_OP: rdata_o = hi_o;
      EXE_MFLO_OP: rdata_o = lo_o;
      default:     rdata_o = '0;
    endcase
  end

  muldiv_core #(
    .WIDTH (WIDTH),
    .ITER  (ITER)
  ) u_core (
    .clk      (clk),
    .rst      (rst),
    .start    (core_start),
    .abort    (flush_i),
    .is_div   (op_div),
    .op_a     (a_mag),
    .op_b     (b_mag),
    .done_c   (core_done),
    .result_c (core_result)
  );

  // Sign restoration and divide-by-zero result on the engine output.
  always_comb begin
    prod   = (signed_q && neg_q) ? -core_result : core_result;
    fix_hi = prod[2*WIDTH-1:WIDTH];
    fix_lo = prod[WIDTH-1:0];
    if (div_q) begin
      if (b_zero_q) begin
        fix_hi = a_q;
        fix_lo = '1;
      end else begin
        fix_lo = (signed_q && neg_q) ? -core_result[WIDTH-1:0] : core_result[WIDTH-1:0];
        fix_hi = (signed_q && a_neg_q) ? -core_result[2*WIDTH-1:WIDTH]
                                       : core_result[2*WIDTH-1:WIDTH];
      end
    end
  end

  // Control state, HI/LO registers and operation context.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= HM_IDLE;
      hi_o     <= '0;
      lo_o     <= '0;
      a_q      <= '0;
      b_zero_q <= 1'b0;
      div_q    <= 1'b0;
      signed_q <= 1'b0;
      neg_q    <= 1'b0;
      a_neg_q  <= 1'b0;
    end else if (flush_i) begin
      state <= HM_IDLE;
    end else begin
      case (state)
        HM_IDLE: begin
          if (start_i) begin
            if (op_md) begin
              a_q      <= a_i;
              b_zero_q <= (b_i == '0);
              div_q    <= op_div;
              signed_q <= op_signed;
              neg_q    <= a_i[WIDTH-1] ^ b_i[WIDTH-1];
              a_neg_q  <= a_i[WIDTH-1];
              state    <= HM_BUSY;
            end else if (alucontrol_i == EXE_MTHI_OP) begin
              hi_o <= a_i;
            end else if (alucontrol_i == EXE_MTLO_OP) begin
              lo_o <= a_i;
            end
          end
        end
        HM_BUSY: begin
          if (core_done) begin
            hi_o  <= fix_hi;
            lo_o  <= fix_lo;
            state <= HM_DONE;
          end
        end
        HM_DONE: state <= HM_IDLE;
        default: state <= HM_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_muldiv.sv
// tb_hilo_muldiv: self-checking bench for hilo_muldiv (vector table, random ops vs model, corner sequences).
module tb_hilo_muldiv;
  import hilo_muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        rst, start_i, flush_i;
  logic [7:0]  alucontrol_i;
  logic [31:0] a_i, b_i;
  logic        stall_o;
  logic [31:0] hi_o, lo_o, rdata_o;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  hilo_muldiv #(.WIDTH(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start_i),
    .alucontrol_i (alucontrol_i),
    .a_i          (a_i),
    .b_i          (b_i),
    .flush_i      (flush_i),
    .stall_o      (stall_o),
    .hi_o         (hi_o),
    .lo_o         (lo_o),
    .rdata_o      (rdata_o)
  );

  typedef struct {
    logic [7:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference: architectural results from plain integer arithmetic.
  function automatic logic [63:0] model(input logic [7:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    longint sa, sb;
    logic [63:0] p;
    logic [31:0] q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    p  = '0;
    if (op == EXE_MULTU_OP) begin
      p = {32'h0, a} * {32'h0, b};
    end else if (op == EXE_MULT_OP) begin
      p = sa * sb;
    end else if (b == 32'h0) begin
      p = {a, 32'hFFFF_FFFF};
    end else if (op == EXE_DIVU_OP) begin
      q = a / b;
      r = a % b;
      p = {r, q};
    end else begin
      q = 32'(sa / sb);
      r = 32'(sa % sb);
      p = {r, q};
    end
    return p;
  endfunction

  // Advance one clock; inputs are changed 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one engine op, count stall cycles, scramble operands mid-flight, check result.
  task automatic run_md(input string name, input logic [7:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] exp);
    int n;
    start_i = 1'b1;
    alucontrol_i = op;
    a_i = a;
    b_i = b;
    #1;
    n = 0;
    while (stall_o && n < 100) begin
      n++;
      step();
      a_i = $urandom;
      b_i = $urandom;
      #1;
    end
    chk({name, "_stall_cycles"}, 64'(n), 64'd33);
    chk({name, "_done_stall"}, {63'h0, stall_o}, 64'h0);
    chk({name, "_hilo"}, {hi_o, lo_o}, exp);
    step();
    start_i = 1'b0;
    alucontrol_i = 8'h00;
    #1;
  endtask

  vec_t vecs[8];
  logic [7:0] md_ops[4];

  initial begin
    rst = 1'b1;
    start_i = 1'b0;
    flush_i = 1'b0;
    alucontrol_i = 8'h00;
    a_i = '0;
    b_i = '0;

    vecs[0] = '{EXE_MULTU_OP, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    vecs[1] = '{EXE_MULT_OP,  32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB};
    vecs[2] = '{EXE_DIV_OP,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[3] = '{EXE_DIVU_OP,  32'h0000_0007, 32'h0000_0002, 32'h0000_0001, 32'h0000_0003};
    vecs[4] = '{EXE_DIVU_OP,  32'h0000_0005, 32'h0000_0000, 32'h0000_0005, 32'hFFFF_FFFF};
    vecs[5] = '{EXE_DIV_OP,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
    vecs[6] = '{EXE_DIV_OP,   32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF};
    vecs[7] = '{EXE_DIV_OP,   32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
    md_ops = '{EXE_MULT_OP, EXE_MULTU_OP, EXE_DIV_OP, EXE_DIVU_OP};

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("reset_hi", {32'h0, hi_o}, 64'h0);
    chk("reset_lo", {32'h0, lo_o}, 64'h0);
    chk("reset_stall", {63'h0, stall_o}, 64'h0);

    // Vector table.
    for (int i = 0; i < 8; i++) begin
      run_md($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, {vecs[i].hi, vecs[i].lo});
    end

    // Random ops against the reference model.
    for (int i = 0; i < 10; i++) begin
      logic [7:0]  op;
      logic [31:0] ra, rb;
      op = md_ops[$urandom_range(0, 3)];
      ra = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
      rb = ($urandom_range(0, 5) == 0) ? 32'h0 : $urandom;
      if ($urandom_range(0, 2) == 0) rb = 32'($urandom_range(1, 9));
      run_md($sformatf("rnd%0d", i), op, ra, rb, model(op, ra, rb));
    end

    // MTHI / MFHI / MTLO / MFLO.
    start_i = 1'b1;
    alucontrol_i = EXE_MTHI_OP;
    a_i = 32'h1234_5678;
    #1;
    chk("mthi_stall", {63'h0, stall_o}, 64'h0);
    step();
    alucontrol_i = EXE_MFHI_OP;
    a_i = 32'h0;
    #1;
    chk("mthi_hi", {32'h0, hi_o}, {32'h0, 32'h1234_5678});
    chk("mfhi_rdata", {32'h0, rdata_o}, {32'h0, 32'h1234_5678});
    chk("mfhi_stall", {63'h0, stall_o}, 64'h0);
    step();
    alucontrol_i = EXE_MTLO_OP;
    a_i = 32'hCAFE_F00D;
    #1;
    chk("mtlo_rdata_zero", {32'h0, rdata_o}, 64'h0);
    step();
    alucontrol_i = EXE_MFLO_OP;
    #1;
    chk("mflo_rdata", {32'h0, rdata_o}, {32'h0, 32'hCAFE_F00D});
    chk("mtlo_hi_kept", {32'h0, hi_o}, {32'h0, 32'h1234_5678});
    step();
    // Unrelated op: ignored, no stall.
    alucontrol_i = 8'h20;
    a_i = 32'hDEAD_BEEF;
    #1;
    chk("other_op_stall", {63'h0, stall_o}, 64'h0);
    chk("other_op_rdata", {32'h0, rdata_o}, 64'h0);
    step();
    chk("other_op_hilo", {hi_o, lo_o}, {32'h1234_5678, 32'hCAFE_F00D});

    // Flush and reset on cycle 10 of a DIVU, starting from HI=0x11, LO=0x22.
    for (int pass = 0; pass < 2; pass++) begin
      alucontrol_i = EXE_MTHI_OP;
      a_i = 32'h11;
      step();
      alucontrol_i = EXE_MTLO_OP;
      a_i = 32'h22;
      step();
      alucontrol_i = EXE_DIVU_OP;
      a_i = 32'd1000;
      b_i = 32'd3;
      for (int c = 0; c < 10; c++) step();
      if (pass == 0) flush_i = 1'b1; else rst = 1'b1;
      #1;
      chk($sformatf("abort%0d_stall_now", pass), {63'h0, stall_o}, 64'h0);
      step();
      flush_i = 1'b0;
      rst = 1'b0;
      start_i = 1'b0;
      alucontrol_i = 8'h00;
      #1;
      chk($sformatf("abort%0d_stall_after", pass), {63'h0, stall_o}, 64'h0);
      repeat (40) step();
      chk($sformatf("abort%0d_hilo", pass), {hi_o, lo_o},
          (pass == 0) ? {32'h11, 32'h22} : 64'h0);
      start_i = 1'b1;
    end
    start_i = 1'b0;

    // Engine still usable after an abort.
    run_md("post_abort", EXE_MULTU_OP, 32'h0001_0000, 32'h0001_0000, 64'h0000_0001_0000_0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
